// File: rtl/seq_rca_add.sv
// Digit-serial ripple-carry adder: adds two WIDTH-bit operands plus carry-in CHUNK bits per clock.
// Optional subtract mode (Sub port) is enabled by defining SEQ_RCA_ADD_SUB_EN.
module seq_rca_add #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SEQ_RCA_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned N   = WIDTH / CHUNK;
  localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CHW = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   add_c;
  logic             last_c;
  logic             msb_cin_c;

  // Chunk select, one-slice add and next-state/datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_ch    = '0;
    b_ch    = '0;

    for (int i = 0; i < int'(N); i++) begin
      if (cnt_q == CW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end

    add_c  = CHW'(a_ch) + CHW'(b_ch) + CHW'(carry_q);
    last_c = (cnt_q == CW'(N - 1));
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin
    msb_cin_c = add_c[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
`ifdef SEQ_RCA_ADD_SUB_EN
          if (Sub) begin
            b_d     = ~B;
            carry_d = 1'b1;
          end
`endif
          sum_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(N); i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = add_c[CHUNK-1:0];
          end
        end
        carry_d = add_c[CHUNK];
        if (last_c) begin
          cout_d  = add_c[CHUNK];
          ovf_d   = add_c[CHUNK] ^ msb_cin_c;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_rca_add.sv
// Self-checking bench for seq_rca_add: directed cases on a CHUNK=4 instance plus
// randomized sweeps on CHUNK=1/5/20 instances against an integer-arithmetic reference.
module tb_seq_rca_add;

  localparam longint MOD  = 64'sd1 <<< 20;
  localparam longint HALF = 64'sd1 <<< 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_sw;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_a, in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  bit sweep_go = 1'b0;

  always #5 clk = ~clk;

  seq_rca_add #(.WIDTH(20), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (in_a),
    .B         (in_b),
    .Cin       (in_cin),
`ifdef SEQ_RCA_ADD_SUB_EN
    .Sub       (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [21:0] ref_add(input logic [19:0] a, input logic [19:0] b,
                                          input logic c, input logic s);
    longint ua, ub, r, sa, sb, sr;
    logic   co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[19] ? ua - MOD : ua;
    sb = b[19] ? ub - MOD : ub;
    if (s) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + longint'(c);
      co = (r >= MOD);
      sr = sa + sb + longint'(c);
    end
    ov = (sr < -HALF) || (sr >= HALF);
    return {ov, co, 20'(r)};
  endfunction

  task automatic do_op(input logic [19:0] a, input logic [19:0] b, input logic c,
                       input logic s, input bit scr);
    logic [21:0] e;
    int lat, w;
    e = ref_add(a, b, c, s);
    in_a = a; in_b = b; in_cin = c; in_sub = s;
    in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (scr) begin
        in_a = 20'($urandom); in_b = 20'($urandom);
        in_cin = 1'($urandom); in_sub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd5);
    chk("sum", 32'(sum), 32'(e[19:0]));
    chk("cout", 32'(cout), 32'(e[20]));
    chk("ovf", 32'(ovf), 32'(e[21]));
    @(posedge clk); #1;
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  // Randomized sweeps at other chunk sizes, run concurrently
  for (genvar g = 0; g < 3; g++) begin : gen_sw
    localparam int unsigned CH = (g == 0) ? 1 : ((g == 1) ? 5 : 20);
    logic        sw_in_valid, sw_in_ready, sw_out_valid, sw_out_ready;
    logic [19:0] sw_a, sw_b, sw_sum;
    logic        sw_cin, sw_sub, sw_cout, sw_ovf;

    seq_rca_add #(.WIDTH(20), .CHUNK(CH)) u_sw (
      .clk       (clk),
      .rst       (rst_sw),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready),
      .A         (sw_a),
      .B         (sw_b),
      .Cin       (sw_cin),
`ifdef SEQ_RCA_ADD_SUB_EN
      .Sub       (sw_sub),
`endif
      .out_valid (sw_out_valid),
      .out_ready (sw_out_ready),
      .Sum       (sw_sum),
      .Cout      (sw_cout),
      .Ovf       (sw_ovf)
    );

    initial begin : sweep
      logic [21:0] e;
      logic [19:0] a, b;
      logic        c, s;
      int          lat, w;
      sw_in_valid = 1'b0; sw_out_ready = 1'b1;
      sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 1000; i++) begin
        a = 20'($urandom); b = 20'($urandom); c = 1'($urandom); s = 1'b0;
`ifdef SEQ_RCA_ADD_SUB_EN
        s = 1'($urandom);
`endif
        e = ref_add(a, b, c, s);
        sw_a = a; sw_b = b; sw_cin = c; sw_sub = s; sw_in_valid = 1'b1;
        w = 0;
        while (!sw_in_ready && w < 50) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        sw_in_valid = 1'b0;
        lat = 0;
        while (!sw_out_valid && lat < 100) begin
          sw_a = 20'($urandom); sw_b = 20'($urandom);
          sw_cin = 1'($urandom); sw_sub = 1'($urandom);
          @(posedge clk); #1;
          lat++;
        end
        chk("sw_latency", 32'(lat), 32'(20 / CH));
        chk("sw_sum", 32'(sw_sum), 32'(e[19:0]));
        chk("sw_cout", 32'(sw_cout), 32'(e[20]));
        chk("sw_ovf", 32'(sw_ovf), 32'(e[21]));
        @(posedge clk); #1;
      end
      n_done++;
    end
  end

  initial begin
    int w;
    rst = 1'b1; rst_sw = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; rst_sw = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    do_op(20'd50, 20'd150, 1'b0, 1'b0, 1'b0);
    chk("basic_sum_const", 32'(sum), 32'd200);
    do_op(20'h7FFFF, 20'd1, 1'b0, 1'b0, 1'b0);
    do_op(20'hFFFFF, 20'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held, new request ignored
    in_a = 20'd1000; in_b = 20'd2345; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_a = 20'd5; in_b = 20'd6;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_sum_hold", 32'(sum), 32'd3345);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_not_queued", 32'(in_ready), 32'd1);

    // Reset while chunk 2 is pending
    in_a = 20'hABCDE; in_b = 20'h12345; in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op(20'd7, 20'd8, 1'b0, 1'b0, 1'b0);
    chk("post_rst_sum_const", 32'(sum), 32'd15);

`ifdef SEQ_RCA_ADD_SUB_EN
    do_op(20'd50, 20'd150, 1'b0, 1'b1, 1'b0);
    chk("sub_neg_const", 32'(sum), 32'hFFF9C);
    do_op(20'h80000, 20'd1, 1'b0, 1'b1, 1'b0);
    chk("sub_ovf_const", 32'(sum), 32'h7FFFF);
`endif

    for (int i = 0; i < 100; i++) begin
      logic s;
      s = 1'b0;
`ifdef SEQ_RCA_ADD_SUB_EN
      s = 1'($urandom);
`endif
      do_op(20'($urandom), 20'($urandom), 1'($urandom), s, 1'b1);
    end

    sweep_go = 1'b1;
    w = 0;
    while (n_done < 3 && w < 60000) begin @(posedge clk); w++; end
    chk("sweep_complete", 32'(n_done), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
